// File: rtl/csrisc_pkg.sv
// Shared constants for the memory access path: FSM encoding, data width, ack timeout.
package csrisc_pkg;

    localparam int WORD_W         = 32;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int TO_CNT_W       = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;

    function automatic logic low_bits_set(input logic [1:0] byte_offset);
        return |byte_offset;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts ack-less ACCESS cycles; expired marks the last cycle an ack may still arrive.
module mem_timeout_ctr
    import csrisc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TO_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Single-word load/store sequencer between control and a request/ack memory port.
// Define CSRISC_ALIGN_CHECK_EN to reject accesses whose addr[1:0] is nonzero.
module mem_access_unit
    import csrisc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

`ifdef CSRISC_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    logic [1:0]        state;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              we_q;
    logic              valid_req;
    logic              accept;
    logic              misaligned;
    logic              ctr_enable;
    logic              expired;

    assign valid_req  = MemRead ^ MemWrite;
    assign accept     = (state == ST_IDLE) && start && valid_req;
    assign misaligned = ALIGN_CHECK & low_bits_set(addr[1:0]);
    assign ctr_enable = (state == ST_ACCESS) && !mem_ack;

    mem_timeout_ctr u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (ctr_enable),
        .expired (expired)
    );

    // Ack is tested before expiry so a response on the final allowed cycle still succeeds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            mem_data <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (!valid_req) begin
                            state <= ST_DONE;
                        end else if (misaligned) begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err     <= 1'b0;
                            addr_q  <= {addr[WORD_W-1:2], 2'b00};
                            wdata_q <= wr_data;
                            we_q    <= MemWrite;
                            state   <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            mem_data <= mem_rdata;
                        end
                        state <= ST_DONE;
                    end else if (expired) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign mem_req   = (state == ST_ACCESS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table with scoreboard plus reset/stray-ack sequence.
module tb_mem_access_unit;

`ifdef CSRISC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam int NO_ACK = 99;

    logic        clk;
    logic        rst;
    logic        start;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_access_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wr_data   (wr_data),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_delay;
        bit          poke;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[10];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_data = 32'h0;
    logic        m_err  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_data"},  mem_data,  32'h0);
        check({tag, "_err"},       {31'h0, err},     32'h0);
        check({tag, "_done"},      {31'h0, done},    32'h0);
        check({tag, "_busy"},      {31'h0, busy},    32'h0);
        check({tag, "_mem_req"},   {31'h0, mem_req}, 32'h0);
        check({tag, "_mem_we"},    {31'h0, mem_we},  32'h0);
        check({tag, "_mem_addr"},  mem_addr,  32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // Model the expected result, queue it, and present a one-cycle start.
    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        bit   valid = v.rd ^ v.wr;
        bit   mis   = ALIGN_EN && (v.addr[1:0] != 2'b00);
        if (!valid) begin
            e = '{m_data, m_err, 2, 0};
        end else if (mis) begin
            m_err = 1'b1;
            e = '{m_data, 1'b1, 2, 0};
        end else if (v.ack_delay < 16) begin
            m_err = 1'b0;
            if (v.rd) m_data = v.rdata;
            e = '{m_data, 1'b0, 3 + v.ack_delay, v.ack_delay + 1};
        end else begin
            m_err = 1'b1;
            e = '{m_data, 1'b1, 18, 16};
        end
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b1;
        MemRead  = v.rd;
        MemWrite = v.wr;
        addr     = v.addr;
        wr_data  = v.wdata;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        exp_t  e;
        int    cyc = 1;
        int    acc = 0;
        bit    got_done = 0;
        string tag = $sformatf("v%0d", idx);
        for (int k = 0; k < 40 && !got_done; k++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (mem_req) begin
                check({tag, "_mem_addr"},  mem_addr,  {v.addr[31:2], 2'b00});
                check({tag, "_mem_we"},    {31'h0, mem_we}, {31'h0, v.wr});
                if (v.wr) check({tag, "_mem_wdata"}, mem_wdata, v.wdata);
                mem_ack   = (acc == v.ack_delay);
                mem_rdata = v.rdata;
                if (acc == 1 && v.poke) begin
                    start    = 1'b1;
                    MemRead  = 1'b1;
                    MemWrite = 1'b0;
                    addr     = 32'h0000_FFF0;
                end
                acc++;
            end else begin
                mem_ack = 1'b0;
                check({tag, "_we_idle"}, {31'h0, mem_we}, 32'h0);
                if (done) begin
                    got_done = 1;
                    e = sb.pop_front();
                    check({tag, "_mem_data"}, mem_data, e.data);
                    check({tag, "_err"},      {31'h0, err}, {31'h0, e.err});
                    check({tag, "_latency"},  cyc, e.lat);
                    check({tag, "_acc_cycles"}, acc, e.acc);
                end
            end
        end
        mem_ack = 1'b0;
        if (!got_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_done_wait got no done want done within 40 cycles", tag);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
        check({tag, "_idle_after"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 0,      1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h5555_5555, 4,      1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          32'hCAFE_F00D, 2,      1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          32'h1111_1111, NO_ACK, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0050, 32'h0,          32'h2222_2222, 0,      1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,          32'h0BAD_CAFE, 15,     1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0054, 32'h0,          32'h3333_3333, 0,      1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,          32'hA5A5_A5A5, 1,      1'b0};
        vecs[8] = '{1'b0, 1'b1, 32'h0000_0022, 32'h8765_4321, 32'h4444_4444, 0,      1'b0};
        vecs[9] = '{1'b0, 1'b1, 32'h0000_0060, 32'h0F0F_0F0F, 32'h6666_6666, NO_ACK, 1'b0};

        rst = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        addr = '0; wr_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        // Reset in the middle of an access, then a stray ack must not revive it.
        @(negedge clk);
        start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h0000_0070;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_req_active", {31'h0, mem_req}, 32'h1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        m_data = 32'h0;
        m_err  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hBADD_00D5;
        repeat (3) begin
            @(negedge clk);
            check("stray_busy",     {31'h0, busy}, 32'h0);
            check("stray_mem_data", mem_data, 32'h0);
            check("stray_done",     {31'h0, done}, 32'h0);
        end
        mem_ack = 1'b0;

        apply_stimulus('{1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h7777_1234, 1, 1'b0});
        check_output('{1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h7777_1234, 1, 1'b0}, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: rst  input  1  reset; asynchronous assertion, active-low.
REQ-003 SHALL have: start  input  1  one-cycle request from control; sampled only in IDLE.
REQ-004 SHALL have: MemRead  input  1  request is a word load.
REQ-005 SHALL have: MemWrite  input  1  request is a word store.
REQ-006 SHALL have: addr  input  32  byte address of the access.
REQ-007 SHALL have: wr_data  input  32  store data.
REQ-008 SHALL have: mem_data  output  32  last loaded word; feeds the writeback data select (PCMemReg=2'b01).
REQ-009 SHALL have: busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have: err  output  1  last access failed (timeout or misalignment).
REQ-012 SHALL have: mem_req, mem_we  output  1 each  memory-side request and write strobe.
REQ-013 SHALL have: mem_addr, mem_wdata  output  32 each  memory-side address and store data.
REQ-014 SHALL have: mem_rdata  input  32  and  mem_ack  input  1  memory-side response.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-016 IDLE + start + (MemRead XOR MemWrite) SHALL latch addr, wr_data and MemWrite, clear err and the timeout counter, and enter ACCESS next cycle.
REQ-017 IDLE + start with MemRead and MemWrite both high or both low SHALL enter DONE without a memory request; mem_data and err SHALL be unchanged.
REQ-018 In ACCESS, mem_req SHALL be 1, mem_we SHALL equal the latched MemWrite, mem_addr SHALL be {latched addr[31:2],2'b00}, and mem_wdata SHALL be the latched wr_data; all four SHALL be stable until exit.
REQ-019 ACCESS + mem_ack SHALL capture mem_rdata into mem_data (loads only) and enter DONE; minimum start-to-done latency SHALL be 3 cycles (start, ACCESS with ack, DONE).
REQ-020 The timeout counter SHALL increment on each ACCESS cycle without mem_ack; ACCESS after TIMEOUT_CYCLES (16) cycles without ack SHALL set err=1, enter DONE, and leave mem_data unchanged.
REQ-021 mem_ack in the same cycle the timeout is reached SHALL count as success (ack wins).
REQ-022 DONE SHALL assert done for exactly one cycle, drive mem_req=0, and return to IDLE.
REQ-023 mem_ack outside ACCESS SHALL be ignored; start outside IDLE SHALL be ignored (no queueing).
REQ-024 mem_req and mem_we SHALL be 0 in every state except ACCESS.

Reset
REQ-025 rst low SHALL force IDLE immediately; mem_data=0, err=0, done=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0.
REQ-026 rst asserted during ACCESS SHALL drop mem_req without waiting for ack; a later stray ack SHALL be ignored per REQ-023.

Configuration
REQ-027 Macro CSRISC_ALIGN_CHECK_EN SHALL control misalignment checking.
REQ-028 With CSRISC_ALIGN_CHECK_EN defined, an accepted start with addr[1:0]!=0 SHALL skip ACCESS, enter DONE with err=1, and issue no memory request.
REQ-029 Without CSRISC_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored and the access SHALL proceed word-aligned per REQ-018.

Structure
REQ-030 Shared package csrisc_pkg SHALL hold the FSM state encoding, WORD_W=32 and TIMEOUT_CYCLES=16.
REQ-031 The timeout counter SHALL be a sub-module mem_timeout_ctr (clear, enable, expired outputs); everything else stays in mem_access_unit.

Verification
REQ-032 Load: addr=0x0000_0010, MemRead=1, ack on 1st ACCESS cycle with mem_rdata=0xDEAD_BEEF -> done on cycle 3, mem_data=0xDEAD_BEEF, err=0.
REQ-033 Store: addr=0x20, wr_data=0x1234_5678, ack after 4 cycles -> mem_we=1 and mem_wdata stable throughout, mem_data unchanged, done once.
REQ-034 Timeout: load, no ack -> err=1 after 16 ACCESS cycles, done pulses, mem_data keeps its previous value; ack coinciding with cycle 16 -> err=0.
REQ-035 Misaligned addr=0x13: with the macro -> err=1, no mem_req; without it -> mem_addr=0x10 and normal completion.
REQ-036 rst pulsed mid-ACCESS, then stray ack -> all outputs at reset values, FSM stays IDLE; start during busy -> ignored.
